hsid_mse_seq: RTL and testbench

Controller that sequences the two-channel MSE datapath for one pixel against the whole HSI library. It issues pixel-buffer and library-memory reads, and drives band_pack_start/last/valid, vctr_ref and the packed operand words into the MSE datapath. It then collects the MSE results and tracks the minimum MSE and the reference vector that produced it. It sits between the accelerator's register/control interface and the MSE datapath.

---
 rtl/hsid_mse_seq.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_hsid_mse_seq.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hsid_mse_seq.sv
// hsid_mse_seq
// Drives one pixel against every library vector through the two-channel MSE
// datapath. It issues pixel-buffer and library reads one pack per cycle and
// aligns the pack control with the returning read data. It also tracks the
// smallest MSE result and the library reference that produced it.
module hsid_mse_seq #(
  parameter int WORD_WIDTH        = 32,
  parameter int HSP_BANDS_WIDTH   = 8,
  parameter int HSP_LIBRARY_WIDTH = 8,
  parameter int DRAIN_CYCLES      = 8
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       start,
  input  logic                                       cancel,
  input  logic [HSP_BANDS_WIDTH-1:0]                 hsi_bands,
  input  logic [HSP_LIBRARY_WIDTH-1:0]               library_size,
  output logic [HSP_BANDS_WIDTH-1:0]                 pixel_addr,
  output logic                                       pixel_rd,
  input  logic [WORD_WIDTH-1:0]                      pixel_data,
  output logic [HSP_LIBRARY_WIDTH+HSP_BANDS_WIDTH-1:0] lib_addr,
  output logic                                       lib_rd,
  input  logic [WORD_WIDTH-1:0]                      lib_data,
  output logic                                       mse_clear,
  output logic                                       band_pack_start,
  output logic                                       band_pack_last,
  output logic                                       band_pack_valid,
  output logic [HSP_LIBRARY_WIDTH-1:0]               vctr_ref,
  output logic [WORD_WIDTH-1:0]                      band_pack_a,
  output logic [WORD_WIDTH-1:0]                      band_pack_b,
  input  logic [WORD_WIDTH-1:0]                      mse_value,
  input  logic [HSP_LIBRARY_WIDTH-1:0]               mse_ref,
  input  logic                                       mse_valid,
  input  logic                                       mse_of,
  output logic                                       busy,
  output logic                                       done,
  output logic [WORD_WIDTH-1:0]                      min_value,
  output logic [HSP_LIBRARY_WIDTH-1:0]               min_ref,
  output logic                                       min_valid,
  output logic                                       of_seen
);

  localparam int BW = HSP_BANDS_WIDTH;
  localparam int LW = HSP_LIBRARY_WIDTH;
  localparam int DW = $clog2(DRAIN_CYCLES + 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_CLEAR  = 3'd1;
  localparam logic [2:0] ST_STREAM = 3'd2;
  localparam logic [2:0] ST_DRAIN  = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [BW-1:0]         PACK_ZERO  = {BW{1'b0}};
  localparam logic [BW-1:0]         PACK_ONE   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [LW-1:0]         REF_ZERO   = {LW{1'b0}};
  localparam logic [LW-1:0]         REF_ONE    = {{(LW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]         DRAIN_ZERO = {DW{1'b0}};
  localparam logic [DW-1:0]         DRAIN_ONE  = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [DW-1:0]         DRAIN_LAST = DW'(DRAIN_CYCLES - 1);
  localparam logic [WORD_WIDTH-1:0] WORD_ZERO  = {WORD_WIDTH{1'b0}};

  // FSM and run context
  logic [2:0]      state_r;
  logic [2:0]      next_state_s;
  logic [BW-1:0]   packs_r;
  logic [LW-1:0]   lib_size_r;
  logic [BW-1:0]   pack_idx_r;
  logic [LW-1:0]   ref_r;
  logic [DW-1:0]   drain_cnt_r;

  // Registered outputs
  logic            busy_r;
  logic            done_r;
  logic            mse_clear_r;
  logic            rd_r;
  logic            pack_valid_r;
  logic            pack_start_r;
  logic            pack_last_r;
  logic [LW-1:0]   vctr_ref_r;
  logic [WORD_WIDTH-1:0] min_value_r;
  logic [LW-1:0]   min_ref_r;
  logic            min_valid_r;
  logic            of_seen_r;

  // Decoded conditions
  logic [BW-1:0]   packs_s;
  logic            start_ok_s;
  logic            abort_s;
  logic            last_pack_s;
  logic            last_ref_s;
  logic            last_issue_s;
  logic            drain_end_s;
  logic            accept_s;
  logic            new_min_s;

  // Decode run-control conditions from the current state and counters
  always_comb begin
    // (b+1)>>1 without a wider intermediate: half the bands plus the odd band
    packs_s      = {1'b0, hsi_bands[BW-1:1]} + {{(BW-1){1'b0}}, hsi_bands[0]};
    start_ok_s   = (state_r == ST_IDLE) && start && !cancel &&
                   (hsi_bands != PACK_ZERO) && (library_size != REF_ZERO);
    abort_s      = cancel && (state_r != ST_IDLE);
    last_pack_s  = (pack_idx_r == (packs_r - PACK_ONE));
    last_ref_s   = (ref_r == (lib_size_r - REF_ONE));
    last_issue_s = (state_r == ST_STREAM) && last_pack_s && last_ref_s;
    drain_end_s  = (state_r == ST_DRAIN) && (drain_cnt_r == DRAIN_LAST);
    accept_s     = (state_r == ST_STREAM) || (state_r == ST_DRAIN) ||
                   (state_r == ST_DONE);
    if (accept_s && mse_valid && (!min_valid_r || (mse_value < min_value_r))) begin
      new_min_s = 1'b1;
    end else begin
      new_min_s = 1'b0;
    end
  end

  // Next-state logic; cancel outside IDLE overrides every other transition
  always_comb begin
    next_state_s = state_r;
    if (abort_s) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_ok_s) begin
            next_state_s = ST_CLEAR;
          end else begin
            next_state_s = ST_IDLE;
          end
        end
        ST_CLEAR: begin
          next_state_s = ST_STREAM;
        end
        ST_STREAM: begin
          if (last_issue_s) begin
            next_state_s = ST_DRAIN;
          end else begin
            next_state_s = ST_STREAM;
          end
        end
        ST_DRAIN: begin
          if (drain_end_s) begin
            next_state_s = ST_DONE;
          end else begin
            next_state_s = ST_DRAIN;
          end
        end
        ST_DONE: begin
          next_state_s = ST_IDLE;
        end
        default: begin
          next_state_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Run context latch plus pack/ref issue counters and the drain counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packs_r     <= PACK_ZERO;
      lib_size_r  <= REF_ZERO;
      pack_idx_r  <= PACK_ZERO;
      ref_r       <= REF_ZERO;
      drain_cnt_r <= DRAIN_ZERO;
    end else if (start_ok_s) begin
      packs_r     <= packs_s;
      lib_size_r  <= library_size;
      pack_idx_r  <= PACK_ZERO;
      ref_r       <= REF_ZERO;
      drain_cnt_r <= DRAIN_ZERO;
    end else if (abort_s || (state_r == ST_CLEAR)) begin
      pack_idx_r  <= PACK_ZERO;
      ref_r       <= REF_ZERO;
      drain_cnt_r <= DRAIN_ZERO;
    end else if (state_r == ST_STREAM) begin
      drain_cnt_r <= DRAIN_ZERO;
      if (last_pack_s) begin
        pack_idx_r <= PACK_ZERO;
        if (last_ref_s) begin
          ref_r <= REF_ZERO;
        end else begin
          ref_r <= ref_r + REF_ONE;
        end
      end else begin
        pack_idx_r <= pack_idx_r + PACK_ONE;
      end
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + DRAIN_ONE;
    end else begin
      drain_cnt_r <= drain_cnt_r;
    end
  end

  // State-derived outputs, registered from the next state so they line up with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      mse_clear_r <= 1'b0;
      rd_r        <= 1'b0;
    end else begin
      busy_r      <= (next_state_s != ST_IDLE);
      done_r      <= (next_state_s == ST_DONE);
      mse_clear_r <= (next_state_s == ST_CLEAR) || abort_s;
      rd_r        <= (next_state_s == ST_STREAM);
    end
  end

  // Datapath-side pack control: issue-cycle values delayed one cycle to meet the read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack_valid_r <= 1'b0;
      pack_start_r <= 1'b0;
      pack_last_r  <= 1'b0;
      vctr_ref_r   <= REF_ZERO;
    end else if (abort_s) begin
      pack_valid_r <= 1'b0;
      pack_start_r <= 1'b0;
      pack_last_r  <= 1'b0;
      vctr_ref_r   <= REF_ZERO;
    end else begin
      pack_valid_r <= rd_r;
      pack_start_r <= rd_r && (pack_idx_r == PACK_ZERO);
      pack_last_r  <= rd_r && last_pack_s;
      vctr_ref_r   <= ref_r;
    end
  end

  // Minimum-MSE tracking and sticky overflow flag; cleared when a run is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min_value_r <= WORD_ZERO;
      min_ref_r   <= REF_ZERO;
      min_valid_r <= 1'b0;
      of_seen_r   <= 1'b0;
    end else if (start_ok_s) begin
      min_value_r <= WORD_ZERO;
      min_ref_r   <= REF_ZERO;
      min_valid_r <= 1'b0;
      of_seen_r   <= 1'b0;
    end else if (abort_s) begin
      min_valid_r <= min_valid_r;
    end else begin
      if (new_min_s) begin
        min_value_r <= mse_value;
        min_ref_r   <= mse_ref;
        min_valid_r <= 1'b1;
      end else begin
        min_valid_r <= min_valid_r;
      end
      if (accept_s && mse_of) begin
        of_seen_r <= 1'b1;
      end else begin
        of_seen_r <= of_seen_r;
      end
    end
  end

  assign pixel_addr      = pack_idx_r;
  assign lib_addr        = {ref_r, pack_idx_r};
  assign pixel_rd        = rd_r;
  assign lib_rd          = rd_r;
  assign mse_clear       = mse_clear_r;
  assign band_pack_valid = pack_valid_r;
  assign band_pack_start = pack_start_r;
  assign band_pack_last  = pack_last_r;
  assign vctr_ref        = vctr_ref_r;
  // Operand words pass straight from memory; gated so they read zero between packs
  assign band_pack_a     = pack_valid_r ? pixel_data : WORD_ZERO;
  assign band_pack_b     = pack_valid_r ? lib_data : WORD_ZERO;
  assign busy            = busy_r;
  assign done            = done_r;
  assign min_value       = min_value_r;
  assign min_ref         = min_ref_r;
  assign min_valid       = min_valid_r;
  assign of_seen         = of_seen_r;

endmodule

// File: tb/tb_hsid_mse_seq.sv
// Directed bench for hsid_mse_seq: memory and MSE datapath stand-ins plus
// per-scenario tasks with hand-computed expectations.
module tb_hsid_mse_seq;

  localparam int WW = 32;
  localparam int BW = 8;
  localparam int LW = 8;
  localparam int DC = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          cancel = 1'b0;
  logic [BW-1:0] hsi_bands = 8'd0;
  logic [LW-1:0] library_size = 8'd0;
  logic [BW-1:0] pixel_addr;
  logic          pixel_rd;
  logic [WW-1:0] pixel_data = 32'd0;
  logic [LW+BW-1:0] lib_addr;
  logic          lib_rd;
  logic [WW-1:0] lib_data = 32'd0;
  logic          mse_clear, band_pack_start, band_pack_last, band_pack_valid;
  logic [LW-1:0] vctr_ref;
  logic [WW-1:0] band_pack_a, band_pack_b;
  logic [WW-1:0] mse_value = 32'd0;
  logic [LW-1:0] mse_ref = 8'd0;
  logic          mse_valid = 1'b0;
  logic          mse_of = 1'b0;
  logic          busy, done, min_valid, of_seen;
  logic [WW-1:0] min_value;
  logic [LW-1:0] min_ref;

  hsid_mse_seq #(.WORD_WIDTH(WW), .HSP_BANDS_WIDTH(BW), .HSP_LIBRARY_WIDTH(LW),
                 .DRAIN_CYCLES(DC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cancel(cancel),
    .hsi_bands(hsi_bands), .library_size(library_size),
    .pixel_addr(pixel_addr), .pixel_rd(pixel_rd), .pixel_data(pixel_data),
    .lib_addr(lib_addr), .lib_rd(lib_rd), .lib_data(lib_data),
    .mse_clear(mse_clear), .band_pack_start(band_pack_start),
    .band_pack_last(band_pack_last), .band_pack_valid(band_pack_valid),
    .vctr_ref(vctr_ref), .band_pack_a(band_pack_a), .band_pack_b(band_pack_b),
    .mse_value(mse_value), .mse_ref(mse_ref), .mse_valid(mse_valid), .mse_of(mse_of),
    .busy(busy), .done(done), .min_value(min_value), .min_ref(min_ref),
    .min_valid(min_valid), .of_seen(of_seen)
  );

  always #5 clk = ~clk;

  // Memories: pixel word = 0x1000 + pack index, library word = 0x2000 + {ref, pack index}
  always @(posedge clk) begin
    if (pixel_rd) pixel_data <= 32'h0000_1000 + 32'(pixel_addr);
    if (lib_rd) lib_data <= 32'h0000_2000 + 32'(lib_addr);
  end

  // Datapath stand-in: result two cycles after the last pack of a vector
  logic [WW-1:0] mse_tab [256];
  logic          of_tab [256];
  logic          dp_v1 = 1'b0;
  logic [LW-1:0] dp_ref1 = 8'd0;
  always @(posedge clk) begin
    dp_v1     <= band_pack_valid && band_pack_last;
    dp_ref1   <= vctr_ref;
    mse_valid <= dp_v1 && !of_tab[dp_ref1];
    mse_of    <= dp_v1 && of_tab[dp_ref1];
    mse_value <= mse_tab[dp_ref1];
    mse_ref   <= dp_ref1;
  end

  // Recorder of valid packs and event counts, sampled on the falling edge
  int rec_n = 0, cyc_cnt = 0, done_cnt = 0, rd_cnt = 0, busy_cnt = 0;
  logic          rec_start [256];
  logic          rec_last  [256];
  logic [LW-1:0] rec_ref   [256];
  logic [WW-1:0] rec_a     [256];
  logic [WW-1:0] rec_b     [256];
  int            rec_cyc   [256];
  always @(negedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (done === 1'b1) done_cnt <= done_cnt + 1;
    if (pixel_rd === 1'b1 || lib_rd === 1'b1) rd_cnt <= rd_cnt + 1;
    if (busy === 1'b1) busy_cnt <= busy_cnt + 1;
    if (band_pack_valid === 1'b1 && rec_n < 256) begin
      rec_start[rec_n] <= band_pack_start;
      rec_last[rec_n]  <= band_pack_last;
      rec_ref[rec_n]   <= vctr_ref;
      rec_a[rec_n]     <= band_pack_a;
      rec_b[rec_n]     <= band_pack_b;
      rec_cyc[rec_n]   <= cyc_cnt;
      rec_n            <= rec_n + 1;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int base, c1, done_at;
  logic clr1, busy_after;

  // Launch a run and wait (bounded) for done; cycle 1 is the cycle after start is sampled
  task automatic go(input logic [BW-1:0] b, input logic [LW-1:0] l);
    int n;
    @(negedge clk);
    hsi_bands = b; library_size = l; start = 1'b1;
    base = rec_n;
    @(negedge clk);
    start = 1'b0;
    clr1 = mse_clear;
    c1 = cyc_cnt;
    n = 1;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    done_at = n;
    @(negedge clk);
    busy_after = busy;
  endtask

  task automatic clear_tabs();
    for (int i = 0; i < 256; i++) begin
      mse_tab[i] = 32'd0;
      of_tab[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, done, mse_clear, pixel_rd, lib_rd, band_pack_valid, band_pack_start,
         band_pack_last, min_valid, of_seen} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b required 0", {busy, done, mse_clear, pixel_rd,
               lib_rd, band_pack_valid, band_pack_start, band_pack_last, min_valid, of_seen});
    end
    n_checks++;
    if ({pixel_addr, lib_addr, vctr_ref, min_ref, min_value} !== 72'd0) begin
      n_fail++;
      $display("FAIL reset_buses: got %h required 0", {pixel_addr, lib_addr, vctr_ref, min_ref, min_value});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [41:0] obs, exp;
    clear_tabs();
    mse_tab[0] = 32'd50; mse_tab[1] = 32'd20; mse_tab[2] = 32'd35;
    go(8'd4, 8'd3);
    n_checks++;
    if (clr1 !== 1'b1) begin n_fail++; $display("FAIL basic_clear: got %b required 1", clr1); end
    n_checks++;
    if (done_at !== 16) begin n_fail++; $display("FAIL basic_done_cycle: got %0d required 16", done_at); end
    n_checks++;
    if (busy_after !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b required 0", busy_after); end
    n_checks++;
    if (rec_n - base !== 6) begin n_fail++; $display("FAIL basic_pack_count: got %0d required 6", rec_n - base); end
    n_checks++;
    if (rec_cyc[base] - c1 !== 2 || rec_cyc[base+5] - c1 !== 7) begin
      n_fail++;
      $display("FAIL basic_valid_timing: got %0d..%0d required 2..7", rec_cyc[base] - c1, rec_cyc[base+5] - c1);
    end
    for (int k = 0; k < 6; k++) begin
      exp = {(k % 2) == 0, (k % 2) == 1, 8'(k / 2),
             16'h1000 + 16'(k % 2), 16'h2000 + 16'((k / 2) * 256 + (k % 2))};
      obs = {rec_start[base+k], rec_last[base+k], rec_ref[base+k], rec_a[base+k][15:0], rec_b[base+k][15:0]};
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL basic_pack%0d: got %h required %h", k, obs, exp); end
    end
    n_checks++;
    if ({min_valid, min_ref, min_value, of_seen} !== {1'b1, 8'd1, 32'd20, 1'b0}) begin
      n_fail++;
      $display("FAIL basic_min: got v=%b ref=%0d val=%0d of=%b required v=1 ref=1 val=20 of=0",
               min_valid, min_ref, min_value, of_seen);
    end
  endtask

  task automatic test_single_band();
    clear_tabs();
    mse_tab[0] = 32'd5; mse_tab[1] = 32'd3;
    go(8'd1, 8'd2);
    n_checks++;
    if (done_at !== 12 || rec_n - base !== 2) begin
      n_fail++;
      $display("FAIL single_timing: got done=%0d packs=%0d required done=12 packs=2", done_at, rec_n - base);
    end
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({rec_start[base+k], rec_last[base+k], rec_ref[base+k]} !== {1'b1, 1'b1, 8'(k)}) begin
        n_fail++;
        $display("FAIL single_pack%0d: got %b%b ref %0d required 11 ref %0d",
                 k, rec_start[base+k], rec_last[base+k], rec_ref[base+k], k);
      end
    end
    n_checks++;
    if ({min_ref, min_value} !== {8'd1, 32'd3}) begin
      n_fail++; $display("FAIL single_min: got ref=%0d val=%0d required ref=1 val=3", min_ref, min_value);
    end
  endtask

  task automatic test_tie();
    clear_tabs();
    mse_tab[0] = 32'd7; mse_tab[1] = 32'd9; mse_tab[2] = 32'd7;
    go(8'd2, 8'd3);
    n_checks++;
    if ({min_valid, min_ref, min_value} !== {1'b1, 8'd0, 32'd7} || done_at !== 13) begin
      n_fail++;
      $display("FAIL tie_min: got ref=%0d val=%0d done=%0d required ref=0 val=7 done=13",
               min_ref, min_value, done_at);
    end
  endtask

  task automatic test_ignore();
    int d0, r0, b0;
    d0 = done_cnt; r0 = rd_cnt; b0 = busy_cnt;
    @(negedge clk); hsi_bands = 8'd4; library_size = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    hsi_bands = 8'd0; library_size = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (15) @(negedge clk);
    hsi_bands = 8'd4; library_size = 8'd3; start = 1'b1; cancel = 1'b1;
    @(negedge clk); start = 1'b0; cancel = 1'b0;
    repeat (15) @(negedge clk);
    n_checks++;
    if (busy_cnt - b0 !== 0) begin n_fail++; $display("FAIL ignore_busy: got %0d busy cycles required 0", busy_cnt - b0); end
    n_checks++;
    if (rd_cnt - r0 !== 0) begin n_fail++; $display("FAIL ignore_reads: got %0d reads required 0", rd_cnt - r0); end
    n_checks++;
    if (done_cnt - d0 !== 0) begin n_fail++; $display("FAIL ignore_done: got %0d done pulses required 0", done_cnt - d0); end
    n_checks++;
    if ({min_valid, min_ref, min_value} !== {1'b1, 8'd0, 32'd7}) begin
      n_fail++; $display("FAIL ignore_min_hold: got ref=%0d val=%0d required ref=0 val=7", min_ref, min_value);
    end
  endtask

  task automatic test_cancel();
    int k, d0;
    clear_tabs();
    mse_tab[0] = 32'd50; mse_tab[1] = 32'd20; mse_tab[2] = 32'd35;
    @(negedge clk); hsi_bands = 8'd4; library_size = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    k = 0;
    while (!(pixel_rd === 1'b1 && lib_addr[15:8] === 8'd1) && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (k >= 50) begin n_fail++; $display("FAIL cancel_reach_ref1: got timeout required ref 1 issue"); end
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    n_checks++;
    if ({mse_clear, band_pack_valid, busy, pixel_rd, lib_rd} !== 5'b10000) begin
      n_fail++;
      $display("FAIL cancel_response: got %b required 10000", {mse_clear, band_pack_valid, busy, pixel_rd, lib_rd});
    end
    d0 = done_cnt;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 0 || min_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL cancel_no_done: got done=%0d min_valid=%b required done=0 min_valid=0", done_cnt - d0, min_valid);
    end
    go(8'd4, 8'd3);
    n_checks++;
    if (done_at !== 16 || rec_n - base !== 6 || {min_ref, min_value} !== {8'd1, 32'd20}) begin
      n_fail++;
      $display("FAIL cancel_rerun: got done=%0d packs=%0d ref=%0d val=%0d required 16 6 1 20",
               done_at, rec_n - base, min_ref, min_value);
    end
  endtask

  task automatic test_overflow();
    clear_tabs();
    mse_tab[0] = 32'd9; mse_tab[1] = 32'd3; of_tab[1] = 1'b1;
    go(8'd2, 8'd2);
    n_checks++;
    if ({of_seen, min_valid, min_ref, min_value} !== {1'b1, 1'b1, 8'd0, 32'd9} || done_at !== 12) begin
      n_fail++;
      $display("FAIL overflow_min: got of=%b ref=%0d val=%0d done=%0d required of=1 ref=0 val=9 done=12",
               of_seen, min_ref, min_value, done_at);
    end
  endtask

  task automatic test_reset_drain();
    int d0;
    clear_tabs();
    mse_tab[0] = 32'd4; mse_tab[1] = 32'd6;
    @(negedge clk); hsi_bands = 8'd2; library_size = 8'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_checks++;
    if ({of_seen, min_valid} !== 2'b00) begin
      n_fail++; $display("FAIL drain_run_clear: got of=%b v=%b required 00", of_seen, min_valid);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if ({busy, min_valid, pixel_rd} !== 3'b110) begin
      n_fail++; $display("FAIL drain_precondition: got %b required 110", {busy, min_valid, pixel_rd});
    end
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, mse_clear, pixel_rd, band_pack_valid, min_valid, of_seen,
         min_value, min_ref, lib_addr} !== 63'd0) begin
      n_fail++;
      $display("FAIL drain_reset_outputs: got busy=%b v=%b val=%0d required all 0", busy, min_valid, min_value);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++;
    if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL drain_no_done: got done=%0d busy=%b required 0 0", done_cnt - d0, busy);
    end
  endtask

  initial begin
    clear_tabs();
    test_reset();
    test_basic();
    test_single_band();
    test_tie();
    test_ignore();
    test_cancel();
    test_overflow();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
